// File: rtl/vx_ahb_mem_adapter.sv
// Bridges the Vortex line-wide memory port onto an AHB-Lite manager, splitting each line into
// sequential 32-bit SINGLE transfers and reassembling read words into one line response.

`ifndef VX_MEM_DATA_WIDTH
`define VX_MEM_DATA_WIDTH 512
`endif
`ifndef VX_MEM_ADDR_WIDTH
`define VX_MEM_ADDR_WIDTH 26
`endif
`ifndef VX_MEM_TAG_WIDTH
`define VX_MEM_TAG_WIDTH 8
`endif

module vx_ahb_mem_adapter #(
  parameter int unsigned DATA_WIDTH   = `VX_MEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = `VX_MEM_ADDR_WIDTH,
  parameter int unsigned TAG_WIDTH    = `VX_MEM_TAG_WIDTH,
  parameter int unsigned BYTEEN_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [BYTEEN_WIDTH-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,

  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,

  output logic                    HSEL,
  output logic                    HWRITE,
  output logic [1:0]              HTRANS,
  output logic [31:0]             HADDR,
  output logic [2:0]              HSIZE,
  output logic [2:0]              HBURST,
  output logic [31:0]             HWDATA,
  output logic [3:0]              HWSTRB,
  input  logic                    HREADY,
  input  logic                    HRESP,
  input  logic [31:0]             HRDATA
);

  localparam int unsigned N   = DATA_WIDTH / 32;
  localparam int unsigned LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned BW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW  = ADDR_WIDTH + LSB;
  localparam int unsigned HW  = (AW > 32) ? AW : 32;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StRsp} state_e;

  state_e                  state_q, state_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic                    rw_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [BYTEEN_WIDTH-1:0] byteen_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [DATA_WIDTH-1:0]   line_q;

  logic          accept;
  logic          beat_done;
  logic          last_beat;
  logic [HW-1:0] haddr_full;

  assign accept    = (state_q == StIdle) && mem_req_valid;
  assign beat_done = (state_q == StData) && HREADY;
  assign last_beat = (beat_q == BW'(N - 1));

  // Byte address of the current beat; the line offset never carries past LSB bits.
  assign haddr_full = HW'({addr_q, {LSB{1'b0}}}) + (HW'(beat_q) << 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      byteen_q <= '0;
      tag_q    <= '0;
      line_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (accept) begin
        rw_q     <= mem_req_rw;
        addr_q   <= mem_req_addr;
        data_q   <= mem_req_data;
        byteen_q <= mem_req_byteen;
        tag_q    <= mem_req_tag;
      end
      // An errored read beat contributes a zero word rather than a bus error to Vortex.
      if (beat_done && !rw_q) begin
        line_q[32*beat_q +: 32] <= HRESP ? 32'h0 : HRDATA;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req_valid) begin
          state_d = StAddr;
          beat_d  = '0;
        end
      end
      StAddr: begin
        if (HREADY) state_d = StData;
      end
      StData: begin
        if (HREADY) begin
          if (!last_beat) begin
            beat_d  = beat_q + 1'b1;
            state_d = StAddr;
          end else begin
            state_d = rw_q ? StIdle : StRsp;
          end
        end
      end
      StRsp: begin
        if (mem_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = 32'h0;
    HWDATA = 32'h0;
    HWSTRB = 4'h0;
    unique case (state_q)
      StAddr: begin
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = rw_q;
        HADDR  = haddr_full[31:0];
      end
      StData: begin
        HSEL   = 1'b1;
        HWRITE = rw_q;
        HADDR  = haddr_full[31:0];
        if (rw_q) begin
          HWDATA = data_q[32*beat_q +: 32];
          HWSTRB = byteen_q[4*beat_q +: 4];
        end
      end
      default: ;
    endcase
  end

  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;

  // Gated by reset so nothing can be accepted while reset is held.
  assign mem_req_ready = (state_q == StIdle) && !reset;
  assign mem_rsp_valid = (state_q == StRsp);
  assign mem_rsp_data  = line_q;
  assign mem_rsp_tag   = tag_q;

endmodule

// File: tb/tb_vx_ahb_mem_adapter.sv
// Directed bench for vx_ahb_mem_adapter with a small AHB subordinate model holding 64 words
// starting at byte address 0x1000.

module tb_vx_ahb_mem_adapter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         mem_req_valid = 1'b0;
  logic         mem_req_rw = 1'b0;
  logic [63:0]  mem_req_byteen = '0;
  logic [25:0]  mem_req_addr = '0;
  logic [511:0] mem_req_data = '0;
  logic [7:0]   mem_req_tag = '0;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [511:0] mem_rsp_data;
  logic [7:0]   mem_rsp_tag;
  logic         mem_rsp_ready = 1'b1;
  logic         HSEL, HWRITE;
  logic [1:0]   HTRANS;
  logic [31:0]  HADDR, HWDATA, HRDATA;
  logic [2:0]   HSIZE, HBURST;
  logic [3:0]   HWSTRB;
  logic         HREADY, HRESP;

  vx_ahb_mem_adapter #(
    .DATA_WIDTH (512),
    .ADDR_WIDTH (26),
    .TAG_WIDTH  (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .HSEL           (HSEL),
    .HWRITE         (HWRITE),
    .HTRANS         (HTRANS),
    .HADDR          (HADDR),
    .HSIZE          (HSIZE),
    .HBURST         (HBURST),
    .HWDATA         (HWDATA),
    .HWSTRB         (HWSTRB),
    .HREADY         (HREADY),
    .HRESP          (HRESP),
    .HRDATA         (HRDATA)
  );

  always #5 clk = ~clk;

  // Subordinate model state.
  logic [31:0] mem [0:63];
  logic [31:0] addr_log [$];
  logic [31:0] wdata_log [$];
  logic [3:0]  strb_log [$];
  logic        write_log [$];
  bit          data_phase;
  logic        dp_write;
  logic [31:0] dp_addr;
  int          xfer_cnt;
  int          stall_cnt;
  bit          stall_prev, unstable;
  logic [31:0] s_addr, s_wdata;
  logic [1:0]  s_trans;
  logic [3:0]  s_strb;
  bit          clr = 1'b0;
  int          wait_beat = -1;
  int          wait_len = 0;
  int          err_beat = -1;

  assign HREADY = !(data_phase && xfer_cnt == wait_beat && stall_cnt < wait_len);
  assign HRESP  = data_phase && xfer_cnt == err_beat;
  assign HRDATA = data_phase ? mem[dp_addr[7:2]] : 32'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      data_phase <= 1'b0;
      stall_prev <= 1'b0;
      stall_cnt  <= 0;
      xfer_cnt   <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
    end else begin
      if (clr) begin
        xfer_cnt  <= 0;
        stall_cnt <= 0;
        unstable  <= 1'b0;
        addr_log.delete();
        wdata_log.delete();
        strb_log.delete();
        write_log.delete();
      end
      if (data_phase) begin
        if (stall_prev && (HADDR != s_addr || HWDATA != s_wdata || HTRANS != s_trans ||
                           HWSTRB != s_strb))
          unstable <= 1'b1;
        stall_prev <= !HREADY;
        s_addr     <= HADDR;
        s_wdata    <= HWDATA;
        s_trans    <= HTRANS;
        s_strb     <= HWSTRB;
        if (!HREADY) begin
          stall_cnt <= stall_cnt + 1;
        end else begin
          data_phase <= 1'b0;
          xfer_cnt   <= xfer_cnt + 1;
          wdata_log.push_back(HWDATA);
          strb_log.push_back(HWSTRB);
          if (dp_write && !HRESP)
            for (int b = 0; b < 4; b++)
              if (HWSTRB[b]) mem[dp_addr[7:2]][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end else begin
        stall_prev <= 1'b0;
      end
      if (HSEL && HTRANS == 2'b10 && HREADY) begin
        data_phase <= 1'b1;
        dp_addr    <= HADDR;
        dp_write   <= HWRITE;
        addr_log.push_back(HADDR);
        write_log.push_back(HWRITE);
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic issue(input logic rw, input logic [25:0] addr, input logic [511:0] data,
                       input logic [63:0] be, input logic [7:0] tag);
    @(negedge clk);
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = addr;
    mem_req_data   = data;
    mem_req_byteen = be;
    mem_req_tag    = tag;
    @(posedge clk);
    #1 mem_req_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until a response or ready-for-next shows up.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1 cyc++;
    end while (!mem_rsp_valid && !mem_req_ready && cyc < 200);
  endtask

  logic [511:0] exp_line, wline, held_data;
  logic [7:0]   held_tag;
  int           cyc;
  bit           ok;

  initial begin
    for (int i = 0; i < 16; i++) exp_line[32*i +: 32] = 32'hA000_0000 + i;
    for (int i = 0; i < 16; i++) wline[32*i +: 32] = i;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready_held", mem_req_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", mem_req_ready, 1'b1);
    check_eq("rst_hsel_htrans", {HSEL, HWRITE, HTRANS}, 4'b0000);
    check_eq("rst_haddr_hwdata", {HADDR, HWDATA, HWSTRB}, 68'h0);
    check_eq("rst_hsize_hburst", {HSIZE, HBURST}, 6'b010_000);
    check_eq("rst_rsp", {mem_rsp_valid, mem_rsp_tag, mem_rsp_data}, 521'h0);

    // Zero-wait read.
    clear_logs();
    issue(1'b0, 26'h40, '0, '0, 8'd5);
    wait_done(cyc);
    check_eq("rd_latency", cyc, 32);
    check_eq("rd_valid", mem_rsp_valid, 1'b1);
    check_eq("rd_data", mem_rsp_data, exp_line);
    check_eq("rd_tag", mem_rsp_tag, 8'd5);
    ok = (addr_log.size() == 16);
    for (int i = 0; i < 16 && ok; i++) if (addr_log[i] != 32'h1000 + 4*i || write_log[i]) ok = 0;
    check_eq("rd_haddr_seq", ok, 1'b1);
    @(posedge clk);
    #1 check_eq("rd_ready_after", {mem_req_ready, mem_rsp_valid}, 2'b10);

    // Full write.
    clear_logs();
    issue(1'b1, 26'h41, wline, {64{1'b1}}, 8'd1);
    wait_done(cyc);
    check_eq("wr_latency", cyc, 32);
    check_eq("wr_no_rsp", {mem_rsp_valid, mem_req_ready}, 2'b01);
    ok = (addr_log.size() == 16 && wdata_log.size() == 16);
    for (int i = 0; i < 16 && ok; i++)
      if (addr_log[i] != 32'h1040 + 4*i || !write_log[i]) ok = 0;
    check_eq("wr_haddr_seq", ok, 1'b1);
    ok = (wdata_log.size() == 16);
    for (int i = 0; i < 16 && ok; i++) if (wdata_log[i] != i || strb_log[i] != 4'hF) ok = 0;
    check_eq("wr_hwdata_strb", ok, 1'b1);
    check_eq("wr_mem_5", mem[21], 32'd5);
    check_eq("wr_mem_15", mem[31], 32'd15);

    // Partial write: only beat 1 enabled, every beat still issued.
    clear_logs();
    for (int i = 0; i < 16; i++) wline[32*i +: 32] = 32'h100 + i;
    issue(1'b1, 26'h41, wline, 64'hF0, 8'd2);
    wait_done(cyc);
    check_eq("pw_latency", cyc, 32);
    ok = (strb_log.size() == 16 && addr_log.size() == 16);
    for (int i = 0; i < 16 && ok; i++) if (strb_log[i] != ((i == 1) ? 4'hF : 4'h0)) ok = 0;
    check_eq("pw_strobes", ok, 1'b1);
    check_eq("pw_mem", {mem[16], mem[17], mem[18]}, {32'd0, 32'h101, 32'd2});

    // Wait states in beat 2's data phase.
    clear_logs();
    wait_beat = 2;
    wait_len  = 3;
    issue(1'b0, 26'h40, '0, '0, 8'd9);
    wait_done(cyc);
    check_eq("ws_latency", cyc, 35);
    check_eq("ws_data_tag", {mem_rsp_tag, mem_rsp_data}, {8'd9, exp_line});
    check_eq("ws_stable", unstable, 1'b0);
    @(posedge clk);
    wait_beat = -1;

    // Response backpressure.
    clear_logs();
    @(negedge clk) mem_rsp_ready = 1'b0;
    issue(1'b0, 26'h40, '0, '0, 8'd3);
    wait_done(cyc);
    check_eq("bp_latency", cyc, 32);
    held_data = mem_rsp_data;
    held_tag  = mem_rsp_tag;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (!mem_rsp_valid || mem_req_ready || mem_rsp_data != held_data ||
             mem_rsp_tag != held_tag) ok = 0;
    end
    check_eq("bp_hold", ok, 1'b1);
    check_eq("bp_data_tag", {held_tag, held_data}, {8'd3, exp_line});
    @(negedge clk) mem_rsp_ready = 1'b1;
    @(posedge clk);
    #1 check_eq("bp_ready_after", {mem_req_ready, mem_rsp_valid}, 2'b10);

    // Reset during beat 7 of a read.
    clear_logs();
    issue(1'b0, 26'h40, '0, '0, 8'd7);
    repeat (15) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_eq("mr_bus_idle", {HSEL, HWRITE, HTRANS, HADDR, HWDATA, HWSTRB}, 72'h0);
    check_eq("mr_rsp_clear", {mem_rsp_valid, mem_rsp_tag, mem_rsp_data}, 521'h0);
    check_eq("mr_req_ready", mem_req_ready, 1'b0);
    @(negedge clk) reset = 1'b0;
    ok = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (mem_rsp_valid || HSEL) ok = 0;
    end
    check_eq("mr_no_rsp", ok, 1'b1);
    check_eq("mr_ready_idle", mem_req_ready, 1'b1);

    // Error response on beat 3 of a read.
    clear_logs();
    err_beat = 3;
    issue(1'b0, 26'h40, '0, '0, 8'd2);
    wait_done(cyc);
    exp_line[32*3 +: 32] = 32'h0;
    check_eq("err_latency", cyc, 32);
    check_eq("err_data_tag", {mem_rsp_tag, mem_rsp_data}, {8'd2, exp_line});
    @(posedge clk);
    err_beat = -1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
